// File: rtl/fft_const_rotator.sv
// Forward radix-8 twiddle rotator for a 64-point FFT stage.
// Two-stage pipeline: registered products, then combine, shift and wrap.
module fft_const_rotator #(
    parameter int INTEGER_SIZE = 6,
    parameter int FRACT_SIZE   = 12,
    parameter int NFFT         = 64,
    localparam int DATA_WIDTH  = INTEGER_SIZE + FRACT_SIZE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         frame_start,
    input  logic signed [DATA_WIDTH-1:0] in_r,
    input  logic signed [DATA_WIDTH-1:0] in_i,
    output logic signed [DATA_WIDTH-1:0] out_r,
    output logic signed [DATA_WIDTH-1:0] out_i,
    output logic                         out_valid,
    output logic                         out_last
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = PW + 1;
    localparam int C_INT = $rtoi(0.70710678 * (2.0 ** FRACT_SIZE) + 0.5);
    localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRACT_SIZE);
    localparam logic signed [DATA_WIDTH-1:0] CC  = DATA_WIDTH'(C_INT);
    localparam logic [5:0] LAST_IDX = 6'(NFFT - 1);

    logic        [5:0]            r_cnt;
    logic        [5:0]            w_idx;
    logic        [1:0]            w_k;
    logic signed [DATA_WIDTH-1:0] w_wr;
    logic signed [DATA_WIDTH-1:0] w_wi;

    logic signed [PW-1:0] r_p_rr;
    logic signed [PW-1:0] r_p_ii;
    logic signed [PW-1:0] r_p_ri;
    logic signed [PW-1:0] r_p_ir;
    logic                 r_s1_valid;
    logic                 r_s1_last;

    logic signed [SW-1:0] w_sum_r;
    logic signed [SW-1:0] w_sum_i;

    logic signed [DATA_WIDTH-1:0] r_out_r;
    logic signed [DATA_WIDTH-1:0] r_out_i;
    logic                         r_out_valid;
    logic                         r_out_last;

    // A qualified frame_start forces this sample onto index 0.
    always_comb begin
        w_idx = (in_valid && frame_start) ? 6'd0 : r_cnt;
        w_k   = w_idx[4] ? w_idx[3:2] : 2'd0;
        w_wr  = ONE;
        w_wi  = '0;
        case (w_k)
            2'd0: begin
                w_wr = ONE;
                w_wi = '0;
            end
            2'd1: begin
                w_wr = CC;
                w_wi = -CC;
            end
            2'd2: begin
                w_wr = '0;
                w_wi = -ONE;
            end
            default: begin
                w_wr = -CC;
                w_wi = -CC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_p_rr     <= '0;
            r_p_ii     <= '0;
            r_p_ri     <= '0;
            r_p_ir     <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_last  <= in_valid && (w_idx == LAST_IDX);
            if (in_valid) begin
                r_cnt  <= w_idx + 6'd1;
                r_p_rr <= PW'(in_r) * PW'(w_wr);
                r_p_ii <= PW'(in_i) * PW'(w_wi);
                r_p_ri <= PW'(in_r) * PW'(w_wi);
                r_p_ir <= PW'(in_i) * PW'(w_wr);
            end
        end
    end

    // One guard bit so the combine cannot overflow before the floor shift.
    assign w_sum_r = SW'(r_p_rr) - SW'(r_p_ii);
    assign w_sum_i = SW'(r_p_ri) + SW'(r_p_ir);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_r     <= '0;
            r_out_i     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_last;
            if (r_s1_valid) begin
                r_out_r <= DATA_WIDTH'(w_sum_r >>> FRACT_SIZE);
                r_out_i <= DATA_WIDTH'(w_sum_i >>> FRACT_SIZE);
            end
        end
    end

    assign out_r     = r_out_r;
    assign out_i     = r_out_i;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_fft_const_rotator.sv
// Scoreboard bench for fft_const_rotator: expected samples are queued at
// drive time and retired as the rotator emits them two cycles later.
module tb_fft_const_rotator;

    localparam int DW = 18;

    typedef struct {
        longint r;
        longint i;
        bit     last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 frame_start = 1'b0;
    logic signed [DW-1:0] in_r = '0;
    logic signed [DW-1:0] in_i = '0;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;
    logic                 out_valid;
    logic                 out_last;

    exp_t   q[$];
    exp_t   e_m;
    int     n_chk = 0;
    int     n_err = 0;
    logic [5:0] m_cnt = '0;
    bit     prev_v = 1'b0;
    bit     mon_en = 1'b0;
    logic [1:0] vpipe = '0;
    logic   rst_seen = 1'b0;
    longint hold_r = 0;
    longint hold_i = 0;

    always #5 clk = ~clk;

    fft_const_rotator dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .in_r        (in_r),
        .in_i        (in_i),
        .out_r       (out_r),
        .out_i       (out_i),
        .out_valid   (out_valid),
        .out_last    (out_last)
    );

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void mdl(input logic [5:0] idx,
                                input longint r, input longint i,
                                output longint er, output longint ei);
        longint wr, wi, pr, pi;
        logic [1:0] k;
        logic signed [DW-1:0] t;
        k = idx[4] ? idx[3:2] : 2'd0;
        case (k)
            2'd0:    begin wr = 4096;  wi = 0;     end
            2'd1:    begin wr = 2896;  wi = -2896; end
            2'd2:    begin wr = 0;     wi = -4096; end
            default: begin wr = -2896; wi = -2896; end
        endcase
        pr = r * wr - i * wi;
        pi = r * wi + i * wr;
        t  = DW'(pr >>> 12);
        er = t;
        t  = DW'(pi >>> 12);
        ei = t;
    endfunction

    function automatic void fexp(input int n, output longint xr, output longint xi);
        int m;
        m = n % 32;
        if (m < 20)      begin xr = 4096;  xi = 0;     end
        else if (m < 24) begin xr = 2896;  xi = -2896; end
        else if (m < 28) begin xr = 0;     xi = -4096; end
        else             begin xr = -2896; xi = -2896; end
    endfunction

    task automatic cyc(input bit v, input bit fs, input bit rs,
                       input logic signed [DW-1:0] r,
                       input logic signed [DW-1:0] i,
                       input bit ux, input longint xr, input longint xi);
        exp_t       e;
        logic [5:0] idx;
        longint     mr, mi;
        @(posedge clk);
        #1;
        rst = rs;
        in_valid = v;
        frame_start = fs;
        in_r = r;
        in_i = i;
        if (rs) begin
            if (prev_v) void'(q.pop_back());
            m_cnt  = '0;
            prev_v = 1'b0;
        end else begin
            prev_v = v;
            if (v) begin
                idx = fs ? 6'd0 : m_cnt;
                mdl(idx, r, i, mr, mi);
                e.r    = ux ? xr : mr;
                e.i    = ux ? xi : mi;
                e.last = (idx == 6'd63);
                q.push_back(e);
                m_cnt = idx + 6'd1;
            end
        end
    endtask

    always @(posedge clk) begin
        rst_seen <= rst;
        if (rst) vpipe <= '0;
        else     vpipe <= {vpipe[0], in_valid};
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", out_valid, vpipe[1]);
            if (rst_seen) begin
                chk("rst_out_r", out_r, 0);
                chk("rst_out_i", out_i, 0);
                chk("rst_out_last", out_last, 0);
                hold_r = 0;
                hold_i = 0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", out_valid, 0);
                end else begin
                    e_m = q.pop_front();
                    chk("out_r", out_r, e_m.r);
                    chk("out_i", out_i, e_m.i);
                    chk("out_last", out_last, e_m.last);
                    hold_r = e_m.r;
                    hold_i = e_m.i;
                end
            end else begin
                chk("hold_r", out_r, hold_r);
                chk("hold_i", out_i, hold_i);
                chk("idle_last", out_last, 0);
            end
        end
    end

    initial begin
        longint xr, xi;
        logic signed [DW-1:0] ra, rb;
        bit v, fs;

        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        repeat (2) cyc(0, 0, 1, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // full frame of unit samples, then the 65th wraps to index 0
        for (int n = 0; n < 64; n++) begin
            fexp(n, xr, xi);
            cyc(1, n == 0, 0, 4096, 0, 1, xr, xi);
        end
        cyc(1, 0, 0, 4096, 0, 1, 4096, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // directed twiddle points inside one frame
        for (int n = 0; n < 29; n++) begin
            ra = DW'($urandom());
            rb = DW'($urandom());
            case (n)
                20: cyc(1, 0, 0, 4096, 0, 1, 2896, -2896);
                21: cyc(1, 0, 0, 4096, 4096, 1, 5792, 0);
                24: cyc(1, 0, 0, 100, 200, 1, 200, -100);
                25: cyc(1, 0, 0, -131072, 0, 1, 0, -131072);
                28: cyc(1, 0, 0, 4096, 0, 1, -2896, -2896);
                default: cyc(1, n == 0, 0, ra, rb, 0, 0, 0);
            endcase
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // gaps, an ignored frame_start and a mid-frame resync
        for (int n = 0; n < 60; n++) begin
            ra = DW'($urandom());
            rb = DW'($urandom());
            v  = ($urandom_range(0, 9) < 6);
            fs = 1'b0;
            if (n == 10) begin v = 1'b0; fs = 1'b1; end
            if (n == 30) begin v = 1'b1; fs = 1'b1; end
            cyc(v, fs, 0, ra, rb, 0, 0, 0);
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // reset with two samples in flight, landing in the k1 region
        for (int n = 0; n < 23; n++) begin
            ra = DW'($urandom());
            rb = DW'($urandom());
            cyc(1, n == 0, 0, ra, rb, 0, 0, 0);
        end
        cyc(1, 0, 1, 4096, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 4096, 0, 1, 4096, 0);
        cyc(1, 0, 0, 4096, 4096, 1, 4096, 4096);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0);

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fft_const_rotator.md
FFT_CONST_ROTATOR -- requirements
Module: fft_const_rotator

Interface
REQ-001 The module SHALL have parameter INTEGER_SIZE, default 6, integer bits of the signed fixed-point sample.
REQ-002 The module SHALL have parameter FRACT_SIZE, default 12, fraction bits; DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE.
REQ-003 The module SHALL have parameter NFFT, default 64, frame length; only 64 is supported.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1, qualifies in_r/in_i/frame_start.
REQ-007 The module SHALL have port frame_start, input, 1, marks sample 0 of a frame when high with in_valid.
REQ-008 The module SHALL have ports in_r and in_i, input, DATA_WIDTH each, signed, the input sample.
REQ-009 The module SHALL have ports out_r and out_i, output, DATA_WIDTH each, signed, the rotated sample.
REQ-010 The module SHALL have port out_valid, output, 1, qualifies out_r/out_i/out_last.
REQ-011 The module SHALL have port out_last, output, 1, marks frame sample 63 at the output.

Function
REQ-012 The module SHALL multiply each valid sample by forward twiddle W8^k = exp(-j*2*pi*k/8), k in 0..3, i.e. the conjugate direction of the IFFT rotator.
REQ-013 Constants SHALL be ONE = 2^FRACT_SIZE and C = round(0.70710678*2^FRACT_SIZE), which is 2896 for FRACT_SIZE=12.
REQ-014 The twiddle table SHALL be: k0 = (ONE, 0); k1 = (C, -C); k2 = (0, -ONE); k3 = (-C, -C).
REQ-015 A 6-bit sample counter cnt SHALL increment by one on each cycle with in_valid high and hold otherwise.
REQ-016 The counter SHALL wrap from 63 to 0.
REQ-017 When frame_start and in_valid are both high, the current sample SHALL use cnt = 0, and the next valid sample SHALL use cnt = 1.
REQ-018 frame_start with in_valid low SHALL be ignored.
REQ-019 The index SHALL be k = cnt[3:2] when cnt[4] = 1, and k = 0 otherwise.
REQ-020 Pipeline stage 1 SHALL register the four full-width (2*DATA_WIDTH) signed products in_r*wr, in_i*wi, in_r*wi and in_i*wr, together with a valid bit and a last bit (last = (cnt == 63)).
REQ-021 Pipeline stage 2 SHALL register out_r = (in_r*wr - in_i*wi) >>> FRACT_SIZE and out_i = (in_r*wi + in_i*wr) >>> FRACT_SIZE.
REQ-022 In stage 2, the sum SHALL be formed at full width before the arithmetic shift (floor rounding), and the result SHALL be truncated to the low DATA_WIDTH bits (wrap, no saturation).
REQ-023 Latency SHALL be exactly 2 cycles: out_valid is high 2 cycles after each accepted in_valid, and out_last follows the same delay.
REQ-024 Bubbles in in_valid SHALL propagate unchanged; there is no backpressure.
REQ-025 When out_valid is low, out_r/out_i SHALL hold their last values.
REQ-026 k = 0 SHALL return the input exactly.
REQ-027 k = 2 SHALL return (in_i, -in_r); negating -2^(DATA_WIDTH-1) SHALL wrap to itself.

Reset
REQ-028 On rst high at a clock edge, cnt, both pipeline valid bits, both last bits, out_r, out_i, out_valid and out_last SHALL all become 0 on that edge.
REQ-029 Reset SHALL take priority over in_valid and frame_start in the same cycle.
REQ-030 Samples in flight when rst asserts SHALL be discarded and produce no out_valid.
REQ-031 The first valid sample after reset release SHALL use cnt = 0, even without frame_start.

Verification
REQ-032 The bench SHALL drive cnt=20 (k1) with in=(4096,0) and check out=(2896,-2896) two cycles later with out_valid=1.
REQ-033 The bench SHALL drive k3 with in=(4096,0) and check out=(-2896,-2896); it SHALL drive k1 with in=(4096,4096) and check out=(5792,0).
REQ-034 The bench SHALL drive k2 with in=(100,200) and check out=(200,-100); it SHALL drive k2 with in=(-131072,0) and check out=(0,-131072) (wrap).
REQ-035 The bench SHALL drive 64 contiguous valid samples of (4096,0) from frame_start and check:
- outputs 0-19 and 32-51 are (4096,0);
- 20-23 and 52-55 are (2896,-2896);
- 24-27 and 56-59 are (0,-4096);
- 28-31 and 60-63 are (-2896,-2896);
- out_last is high only on output 63;
- the 65th sample uses cnt=0.
REQ-036 The bench SHALL insert in_valid gaps and a mid-frame frame_start and check that the counter holds across gaps, resyncs to 0, and that out_valid mirrors in_valid delayed by 2 cycles.
REQ-037 The bench SHALL assert rst for 1 cycle while 2 samples are in flight and check that out_valid stays 0 for the next 2 cycles and that the next sample uses k = 0.
